// File: rtl/freq_result_uart_tx_if.sv
// Result hand-off between the frequency-measure core and the UART framer.
// The producer drives the count pair and read_over; the framer drives the line and status.
interface freq_result_if;
    logic [31:0] read_fx_cnt;
    logic [31:0] read_gate_cnt;
    logic        read_over;
    logic        uart_tx;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    modport master (
        output read_fx_cnt, read_gate_cnt, read_over,
        input  uart_tx, busy, frame_done, overrun
    );

    modport slave (
        input  read_fx_cnt, read_gate_cnt, read_over,
        output uart_tx, busy, frame_done, overrun
    );
endinterface

// File: rtl/freq_result_uart_tx.sv
// Latches a frequency-measure result on each read_over rising edge and sends it
// as a 10-byte 8N1 frame: header, fx (MSB first), gate (MSB first), XOR checksum.
module freq_result_uart_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    freq_result_if.slave res
);
    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
    localparam logic [15:0] BIT_END  = 16'(BAUD_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [31:0] fx_q;
    logic [31:0] gate_q;
    logic        read_over_d;
    logic        tx_q;
    logic        frame_done_q;
    logic        overrun_q;
    logic        new_res;
    logic        busy_int;
    logic        bit_end;
    logic [7:0]  checksum;
    logic [7:0]  cur_byte;

    assign new_res  = res.read_over & ~read_over_d;
    assign busy_int = (state != S_IDLE);
    assign bit_end  = (baud_cnt == BIT_END);
    assign checksum = fx_q[31:24] ^ fx_q[23:16] ^ fx_q[15:8] ^ fx_q[7:0]
                    ^ gate_q[31:24] ^ gate_q[23:16] ^ gate_q[15:8] ^ gate_q[7:0];

    always_comb begin
        cur_byte = checksum;
        case (byte_idx)
            4'd0: cur_byte = HEADER;
            4'd1: cur_byte = fx_q[31:24];
            4'd2: cur_byte = fx_q[23:16];
            4'd3: cur_byte = fx_q[15:8];
            4'd4: cur_byte = fx_q[7:0];
            4'd5: cur_byte = gate_q[31:24];
            4'd6: cur_byte = gate_q[23:16];
            4'd7: cur_byte = gate_q[15:8];
            4'd8: cur_byte = gate_q[7:0];
            default: cur_byte = checksum;
        endcase
    end

    // tx_q is loaded with the level of the upcoming bit on the transition edge,
    // so the line changes exactly on the baud boundary with no extra stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            fx_q         <= '0;
            gate_q       <= '0;
            read_over_d  <= 1'b0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            read_over_d  <= res.read_over;
            frame_done_q <= 1'b0;
            overrun_q    <= new_res & busy_int;
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    if (new_res) begin
                        fx_q     <= res.read_fx_cnt;
                        gate_q   <= res.read_gate_cnt;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tx_q     <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= cur_byte[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx != 4'd9) begin
                            byte_idx <= byte_idx + 4'd1;
                            tx_q     <= 1'b0;
                            state    <= S_START;
                        end else begin
                            tx_q         <= 1'b1;
                            frame_done_q <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign res.uart_tx    = tx_q;
    assign res.busy       = busy_int;
    assign res.frame_done = frame_done_q;
    assign res.overrun    = overrun_q;
endmodule

// File: doc/freq_result_uart_tx.md
# freq_result_uart_tx

Consumer end of the frequency-measurement result interface. It captures the `read_fx_cnt` / `read_gate_cnt` pair on each rising edge of `read_over`, packs the pair into a fixed 10-byte frame, and serializes it as 8N1 UART on `uart_tx` for the host link. It sits between the frequency-measure core and the board TX pin, in the same `clk` domain as the measurement result registers.

## Interface
- `CLK_FREQ`, default 50_000_000: `clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s. `BAUD_DIV = CLK_FREQ / BAUD` (integer division, truncating); 434 at the defaults. `BAUD_DIV` must be in the range 2..65535.
- `HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: active-low reset, synchronous to `clk`. One clock; reset is synchronous and active-low.
- `read_fx_cnt`, input, 32: measured input-signal edge count.
- `read_gate_cnt`, input, 32: gate length in `clk` cycles.
- `read_over`, input, 1: result-valid level; its rising edge marks a new result.
- `uart_tx`, output, 1: serial line, idles high; driven from a register.
- `busy`, output, 1: high from capture until the frame completes.
- `frame_done`, output, 1: one-cycle pulse when the last stop bit completes.
- `overrun`, output, 1: one-cycle pulse when a result edge arrives while `busy` is high.

## Operation
- Edge detect: register `read_over_d`, reset value 0. `new_res = read_over & ~read_over_d`. If `read_over` is already high in the first cycle after reset, that counts as an edge and a frame is sent.
- When `new_res` is high and `busy` is low:
  - latch `fx_q <= read_fx_cnt` and `gate_q <= read_gate_cnt`;
  - set byte index to 0;
  - enter START.
- When `new_res` is high and `busy` is high: the result is dropped, `overrun` pulses for 1 cycle, and the frame in flight is not disturbed.
- Frame, bytes 0..9:
  - byte 0: `HEADER`;
  - bytes 1..4: `fx_q[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`;
  - bytes 5..8: `gate_q`, MSB byte first;
  - byte 9: XOR of bytes 1..8.
  - The checksum is computed from the latched values, so input changes after capture have no effect.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). There is no gap between bytes or between frames beyond the stop bit.
- FSM:
  - IDLE: `uart_tx` = 1, `busy` = 0. Go to START on an accepted edge.
  - START: drive 0 for `BAUD_DIV` cycles, then go to DATA with bit index 0.
  - DATA: drive `byte[bit]` for `BAUD_DIV` cycles each. After bit 7, go to STOP.
  - STOP: drive 1 for `BAUD_DIV` cycles. Then, if byte index < 9, increment it and go to START; otherwise go to IDLE and pulse `frame_done`.
- Baud counter: 16 bits, counts 0..`BAUD_DIV`-1, and is cleared on every state or bit change.
- Synchronous reset mid-frame: at the next `clk` edge with `rst_n` = 0, all state returns to IDLE and the partial frame is abandoned, never resumed.

## Timing
- Reset values:
  - `uart_tx` = 1;
  - `busy`, `frame_done`, `overrun` = 0;
  - `fx_q`, `gate_q`, `read_over_d`, all counters = 0.
- Let edge k be the clock edge at which `new_res` is sampled high with `busy` low. After edge k, `uart_tx` = 0 and `busy` = 1; capture latency is 1 cycle.
- Each bit lasts exactly `BAUD_DIV` cycles. One frame is 100·`BAUD_DIV` cycles.
- After edge k+100·`BAUD_DIV`: `busy` = 0 and `frame_done` = 1 for one cycle, with `uart_tx` = 1.
- An edge sampled at that same edge k+100·`BAUD_DIV` is seen while `busy` is still 1 at sampling. It is dropped and `overrun` pulses.
- An edge one cycle later is accepted. Back-to-back frames are therefore separated by at least 1 idle cycle.
- A `read_over` that stays high, or that toggles faster than a frame, produces at most one frame per rising edge accepted while idle.

## Test plan
Parameters for all scenarios: `CLK_FREQ` = 1_000_000, `BAUD` = 100_000, so `BAUD_DIV` = 10.
1. Basic frame: drive `fx` = 32'h000186A0 and `gate` = 32'h01406F41, then pulse `read_over` 0→1. Required: `uart_tx` = 0 one cycle later; the decoded bytes are A5 00 01 86 A0 01 40 6F 41 48; `frame_done` pulses 1000 cycles after capture.
2. Bit timing: sample `uart_tx` at mid-bit on every bit. Required: every level holds for exactly 10 cycles, data is LSB first, each stop bit is 1, and there are no idle cycles between bytes.
3. Overrun: a second `read_over` rising edge arrives 300 cycles into a frame with different counts. Required: `overrun` pulses once, the frame in flight is unchanged, and no second frame is sent.
4. Input change after capture: change both count inputs 1 cycle after capture. Required: the frame carries the originally latched values and checksum.
5. Reset mid-frame: assert `rst_n` = 0 at cycle 450 for 2 cycles. Required: `uart_tx` = 1 and `busy` = 0 after the first reset edge; a new edge after release produces a complete, correct frame.
6. Level hold and boundary: hold `read_over` high for 3000 cycles. Required: exactly one frame. Separately, an edge at cycle 1000 produces `overrun`, while an edge at cycle 1001 starts a new frame.
